// File: rtl/pll_ctrl_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_ctrl_pkg;

  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_FILTER  = 1024;
  localparam int DEF_LOCK_TIMEOUT = 65536;
  localparam int DEF_MAX_RETRY    = 3;

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_FILTER,
    ST_RUN,
    ST_FAULT
  } pll_state_t;

  typedef struct packed {
    logic pll_rst;
    logic sys_reset_n;
    logic ready;
    logic fault;
  } pll_outs_t;

  // Output values that belong to a state; registered alongside the state itself.
  function automatic pll_outs_t state_outs(input pll_state_t s);
    pll_outs_t o;
    o.pll_rst     = (s == ST_RESET_PLL) || (s == ST_FAULT);
    o.sys_reset_n = (s == ST_RUN);
    o.ready       = (s == ST_RUN);
    o.fault       = (s == ST_FAULT);
    return o;
  endfunction

  function automatic int timer_bits(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for a filtered lock, then releases
// sys_reset_n; retries on timeout and parks in FAULT after MAX_RETRY timeouts.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_FILTER  = DEF_LOCK_FILTER,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic                             refclk,
  input  logic                             rst_n,
  input  logic                             req_reset,
  input  logic                             pll_locked,
  output logic                             pll_rst,
  output logic                             sys_reset_n,
  output logic                             ready,
  output logic                             fault,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
  output logic [7:0]                       lock_lost_cnt
);

  localparam int TW = timer_bits(RST_CYCLES, LOCK_FILTER, LOCK_TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  // The lock cycle seen in WAIT_LOCK already counts toward the filter window.
  localparam logic [TW-1:0] FILT_LAST = TW'(LOCK_FILTER - 2);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  pll_state_t    state;
  pll_outs_t     outs;
  logic [TW-1:0] timer;
  logic          lock;

  sync2 u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RESET_PLL;
      outs          <= state_outs(ST_RESET_PLL);
      timer         <= '0;
      retry_cnt     <= '0;
      lock_lost_cnt <= '0;
    end else if (req_reset) begin
      state     <= ST_RESET_PLL;
      outs      <= state_outs(ST_RESET_PLL);
      timer     <= '0;
      retry_cnt <= '0;
    end else begin
      case (state)
        ST_RESET_PLL: begin
          if (timer == RST_LAST) begin
            state <= ST_WAIT_LOCK;
            outs  <= state_outs(ST_WAIT_LOCK);
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock) begin
            state <= ST_FILTER;
            outs  <= state_outs(ST_FILTER);
            timer <= '0;
          end else if (timer == TO_LAST) begin
            timer     <= '0;
            retry_cnt <= retry_cnt + RW'(1);
            if (retry_cnt + RW'(1) == RETRY_LIM) begin
              state <= ST_FAULT;
              outs  <= state_outs(ST_FAULT);
            end else begin
              state <= ST_RESET_PLL;
              outs  <= state_outs(ST_RESET_PLL);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_FILTER: begin
          if (!lock) begin
            state <= ST_WAIT_LOCK;
            outs  <= state_outs(ST_WAIT_LOCK);
            timer <= '0;
          end else if (timer == FILT_LAST) begin
            state <= ST_RUN;
            outs  <= state_outs(ST_RUN);
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_RUN: begin
          if (!lock) begin
            if (lock_lost_cnt != 8'hFF) lock_lost_cnt <= lock_lost_cnt + 8'd1;
            retry_cnt <= '0;
            state     <= ST_RESET_PLL;
            outs      <= state_outs(ST_RESET_PLL);
            timer     <= '0;
          end
        end
        ST_FAULT: begin
          timer <= '0;
        end
        default: begin
          state <= ST_RESET_PLL;
          outs  <= state_outs(ST_RESET_PLL);
          timer <= '0;
        end
      endcase
    end
  end

  assign pll_rst     = outs.pll_rst;
  assign sys_reset_n = outs.sys_reset_n;
  assign ready       = outs.ready;
  assign fault       = outs.fault;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with a cycle-level reference model and
// per-cycle output comparison, plus hand-computed timing checks.
module tb_pll_reset_ctrl;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_FILTER  = 8;
  localparam int LOCK_TIMEOUT = 32;
  localparam int MAX_RETRY    = 2;

  localparam int M_RST   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_FILT  = 2;
  localparam int M_RUN   = 3;
  localparam int M_FAULT = 4;

  logic       refclk;
  logic       rst_n;
  logic       req_reset;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] lock_lost_cnt;

  int checks   = 0;
  int failures = 0;

  pll_reset_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_FILTER  (LOCK_FILTER),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .req_reset     (req_reset),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .sys_reset_n   (sys_reset_n),
    .ready         (ready),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_lost_cnt (lock_lost_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Reference model: phase tracked by entry cycle number and lock streak length.
  int m_mode   = M_RST;
  int m_cyc    = 0;
  int m_entry  = 0;
  int m_streak = 0;
  int m_retry  = 0;
  int m_lost   = 0;
  bit m_s1     = 1'b0;
  bit m_s2     = 1'b0;

  task automatic enter(input int md);
    m_mode   = md;
    m_entry  = m_cyc;
    m_streak = 0;
  endtask

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_RST; m_cyc = 0; m_entry = 0; m_streak = 0;
      m_retry = 0; m_lost = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin : model_step
      bit lk;
      lk   = m_s2;
      m_s2 = m_s1;
      m_s1 = pll_locked;
      m_cyc++;
      if (req_reset) begin
        enter(M_RST);
        m_retry = 0;
      end else begin
        case (m_mode)
          M_RST:  if (m_cyc - m_entry == RST_CYCLES) enter(M_WAIT);
          M_WAIT: begin
            if (lk) begin
              enter(M_FILT);
              m_streak = 1;
            end else if (m_cyc - m_entry == LOCK_TIMEOUT) begin
              m_retry++;
              enter((m_retry == MAX_RETRY) ? M_FAULT : M_RST);
            end
          end
          M_FILT: begin
            if (!lk) enter(M_WAIT);
            else begin
              m_streak++;
              if (m_streak == LOCK_FILTER) enter(M_RUN);
            end
          end
          M_RUN: begin
            if (!lk) begin
              if (m_lost < 255) m_lost++;
              m_retry = 0;
              enter(M_RST);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge refclk) begin : compare
    logic [13:0] act_v;
    logic [13:0] exp_v;
    act_v = {pll_rst, sys_reset_n, ready, fault, retry_cnt, lock_lost_cnt};
    exp_v = {(m_mode == M_RST || m_mode == M_FAULT), (m_mode == M_RUN), (m_mode == M_RUN),
             (m_mode == M_FAULT), 2'(m_retry), 8'(m_lost)};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL model_cmp t=%0t got %b expected %b", $time, act_v, exp_v);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  int hi, n, n2, stuck, r38, r39;

  initial begin
    rst_n = 1'b0; req_reset = 1'b0; pll_locked = 1'b0;
    tick(2);
    check("reset_outputs", int'({pll_rst, sys_reset_n, ready, fault, retry_cnt, lock_lost_cnt}), 14'h2000);

    // Nominal bring-up
    rst_n = 1'b1;
    hi = pll_rst ? 1 : 0;
    for (int i = 1; i <= 10; i++) begin tick(1); if (pll_rst) hi++; end
    check("bringup_pll_rst_pulse", hi, 4);
    pll_locked = 1'b1;
    n = 0; while (!ready && n < 40) begin tick(1); n++; end
    check("bringup_lock_to_ready", n, 10);
    check("bringup_sys_reset_n", sys_reset_n, 1);
    check("bringup_retry_cnt", retry_cnt, 0);

    // Loss of lock in RUN
    tick(3);
    pll_locked = 1'b0;
    n = 0; while (sys_reset_n && n < 10) begin tick(1); n++; end
    check("loss_sys_reset_latency", n, 3);
    check("loss_lock_lost_cnt", lock_lost_cnt, 1);
    hi = pll_rst ? 1 : 0;
    for (int i = 0; i < 8; i++) begin tick(1); if (pll_rst) hi++; end
    check("loss_pll_rst_pulse", hi, 4);

    // Glitchy lock: 5 high, 1 low, then steady
    pll_locked = 1'b1; tick(5);
    pll_locked = 1'b0; tick(1);
    pll_locked = 1'b1;
    n = 0; while (!ready && n < 40) begin tick(1); n++; end
    check("glitch_second_raise_to_ready", n, 10);

    // Timeouts into FAULT
    tick(2);
    pll_locked = 1'b0;
    hi = 0; r38 = -1; r39 = -1;
    for (int i = 1; i <= 74; i++) begin
      tick(1);
      if (pll_rst) hi++;
      if (i == 38) r38 = retry_cnt;
      if (i == 39) r39 = retry_cnt;
    end
    check("timeout_pll_rst_high_cycles", hi, 8);
    check("timeout_retry_before_1st", r38, 0);
    check("timeout_retry_after_1st", r39, 1);
    tick(1);
    check("timeout_fault", fault, 1);
    check("timeout_retry_cnt", retry_cnt, 2);
    check("fault_pll_rst", pll_rst, 1);
    tick(5);
    check("fault_hold", int'({fault, pll_rst}), 3);

    // Software re-sequence out of FAULT
    req_reset = 1'b1; tick(1); req_reset = 1'b0;
    check("req_fault_cleared", fault, 0);
    check("req_retry_cleared", retry_cnt, 0);
    check("req_lost_kept", lock_lost_cnt, 2);
    hi = pll_rst ? 1 : 0;
    for (int i = 0; i < 8; i++) begin tick(1); if (pll_rst) hi++; end
    check("req_pll_rst_pulse", hi, 4);

    // req_reset on the same edge as the WAIT_LOCK timeout
    tick(27);
    req_reset = 1'b1; tick(1); req_reset = 1'b0;
    check("simul_retry_cnt", retry_cnt, 0);
    check("simul_pll_rst", pll_rst, 1);

    // req_reset inside RESET_PLL restarts the pulse
    tick(1);
    req_reset = 1'b1; tick(1); req_reset = 1'b0;
    n = 0; while (pll_rst && n < 10) begin tick(1); n++; end
    check("restart_pulse_remaining", n, 4);

    // Saturation of lock_lost_cnt
    stuck = 0;
    for (int i = 1; i <= 256; i++) begin
      pll_locked = 1'b1;
      n = 0; while (!ready && n < 60) begin tick(1); n++; end
      if (n == 60) stuck++;
      pll_locked = 1'b0;
      n2 = 0; while (sys_reset_n && n2 < 10) begin tick(1); n2++; end
      if (n2 == 10) stuck++;
      if (i == 252) check("sat_lost_254", lock_lost_cnt, 254);
    end
    check("sat_loop_no_stall", stuck, 0);
    check("sat_lost_255", lock_lost_cnt, 255);

    // Asynchronous reset mid-FILTER
    pll_locked = 1'b1;
    n = 0; while (pll_rst && n < 10) begin tick(1); n++; end
    tick(3);
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", int'({pll_rst, sys_reset_n, ready, fault, retry_cnt, lock_lost_cnt}), 14'h2000);
    tick(2);
    rst_n = 1'b1;
    n = 0; while (!ready && n < 60) begin tick(1); n++; end
    check("rerelease_to_ready", n, 12);
    check("rerelease_lost_cnt", lock_lost_cnt, 0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
